reg_vec_rr_writer: RTL and testbench

Round-robin write controller for a small register vector. Up to three requesters each present a valid/ready write (entry index plus data), and the block grants one per cycle with rotating priority. The granted write commits into the register vector, whose contents and per-entry written flags drive the outputs. It sits in front of the delay-register vector so several producers share a single write path without starvation.

---
 rtl/reg_vec_rr_writer_pkg.sv | 20 ++
 rtl/reg_vec_rr_writer_if.sv | 34 +++
 rtl/reg_vec_rr_writer_arb.sv | 30 +++
 rtl/reg_vec_rr_writer.sv | 122 ++++++++++++
 tb/tb_reg_vec_rr_writer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/reg_vec_rr_writer_pkg.sv
// Shared constants and types for the round-robin register-vector writer.
package reg_vec_pkg;

    localparam int N_REQ = 3;
    localparam int DEPTH = 3;
    localparam int WIDTH = 3;
    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] grant_id_t;
    typedef logic [WIDTH-1:0] data_t;

    // Pointer advances to the requester after the one just granted.
    function automatic grant_id_t next_ptr(input grant_id_t g);
        if (int'(g) >= N_REQ - 1) begin
            return '0;
        end
        return grant_id_t'(g + 1'b1);
    endfunction

endpackage

// File: rtl/reg_vec_rr_writer_if.sv
// Write-request bundle for the three requesters sharing the register vector.
interface reg_vec_rr_writer_if;
    import reg_vec_pkg::*;

    logic      req_valid_0;
    grant_id_t req_idx_0;
    data_t     req_data_0;
    logic      req_ready_0;

    logic      req_valid_1;
    grant_id_t req_idx_1;
    data_t     req_data_1;
    logic      req_ready_1;

    logic      req_valid_2;
    grant_id_t req_idx_2;
    data_t     req_data_2;
    logic      req_ready_2;

    modport master (
        output req_valid_0, req_idx_0, req_data_0,
        output req_valid_1, req_idx_1, req_data_1,
        output req_valid_2, req_idx_2, req_data_2,
        input  req_ready_0, req_ready_1, req_ready_2
    );

    modport slave (
        input  req_valid_0, req_idx_0, req_data_0,
        input  req_valid_1, req_idx_1, req_data_1,
        input  req_valid_2, req_idx_2, req_data_2,
        output req_ready_0, req_ready_1, req_ready_2
    );

endinterface

// File: rtl/reg_vec_rr_writer_arb.sv
// Combinational rotating-priority arbiter; the pointer register lives in the parent.
module rr_arbiter
    import reg_vec_pkg::*;
(
    input  logic [N_REQ-1:0] valid,
    input  grant_id_t        ptr,
    output logic [N_REQ-1:0] gnt,
    output grant_id_t        gnt_id,
    output logic             any_grant
);

    int unsigned cand;

    // Scan ptr, ptr+1, ... modulo N_REQ; the first valid requester wins.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        any_grant = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (32'(ptr) + i) % N_REQ;
            if (!any_grant && valid[cand]) begin
                gnt[cand] = 1'b1;
                gnt_id    = grant_id_t'(cand);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_vec_rr_writer.sv
// Round-robin write controller: one granted write per cycle into a small register vector.
module reg_vec_rr_writer
    import reg_vec_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    reg_vec_rr_writer_if.slave   req,
    input  logic                 clr_err,
    output data_t                out_0,
    output data_t                out_1,
    output data_t                out_2,
    output logic                 out_vld_0,
    output logic                 out_vld_1,
    output logic                 out_vld_2,
    output grant_id_t            last_grant,
    output logic                 err
);

    logic [N_REQ-1:0] valid_vec;
    logic [N_REQ-1:0] gnt;
    grant_id_t        gnt_id;
    logic             any_grant;
    grant_id_t        idx_vec  [N_REQ];
    data_t            data_vec [N_REQ];
    grant_id_t        sel_idx;
    data_t            sel_data;
    logic             wr_ok;
    logic             wr_bad;

    data_t            entry_q [DEPTH];
    data_t            entry_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    grant_id_t        ptr_q, ptr_d;
    grant_id_t        last_grant_q, last_grant_d;
    logic             err_q, err_d;

    // Reset masks requests so no handshake completes while it is high.
    assign valid_vec = {req.req_valid_2, req.req_valid_1, req.req_valid_0} & {N_REQ{~reset}};

    assign idx_vec[0]  = req.req_idx_0;
    assign idx_vec[1]  = req.req_idx_1;
    assign idx_vec[2]  = req.req_idx_2;
    assign data_vec[0] = req.req_data_0;
    assign data_vec[1] = req.req_data_1;
    assign data_vec[2] = req.req_data_2;

    rr_arbiter u_arb (
        .valid     (valid_vec),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .any_grant (any_grant)
    );

    assign req.req_ready_0 = gnt[0];
    assign req.req_ready_1 = gnt[1];
    assign req.req_ready_2 = gnt[2];

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                sel_idx  = idx_vec[k];
                sel_data = data_vec[k];
            end
        end
    end

    assign wr_ok  = any_grant && (32'(sel_idx) <  32'(DEPTH));
    assign wr_bad = any_grant && (32'(sel_idx) >= 32'(DEPTH));

    always_comb begin
        entry_d      = entry_q;
        vld_d        = vld_q;
        ptr_d        = ptr_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        if (any_grant) begin
            ptr_d        = next_ptr(gnt_id);
            last_grant_d = gnt_id;
        end
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (wr_ok && (32'(sel_idx) == j)) begin
                entry_d[j] = sel_data;
                vld_d[j]   = 1'b1;
            end
        end
        // A new bad write outranks a clear in the same cycle.
        if (wr_bad) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q      <= '{default: '0};
            vld_q        <= '0;
            ptr_q        <= '0;
            last_grant_q <= '0;
            err_q        <= 1'b0;
        end else begin
            entry_q      <= entry_d;
            vld_q        <= vld_d;
            ptr_q        <= ptr_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    assign out_0      = entry_q[0];
    assign out_1      = entry_q[1];
    assign out_2      = entry_q[2];
    assign out_vld_0  = vld_q[0];
    assign out_vld_1  = vld_q[1];
    assign out_vld_2  = vld_q[2];
    assign last_grant = last_grant_q;
    assign err        = err_q;

endmodule

// File: tb/tb_reg_vec_rr_writer.sv
// Directed bench for reg_vec_rr_writer with hand-computed expectations.
module tb_reg_vec_rr_writer;
    import reg_vec_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    logic      clr_err;
    data_t     out_0, out_1, out_2;
    logic      out_vld_0, out_vld_1, out_vld_2;
    grant_id_t last_grant;
    logic      err;

    int checks = 0;
    int errors = 0;

    reg_vec_rr_writer_if rif ();

    always #5 clk = ~clk;

    reg_vec_rr_writer dut (
        .clk        (clk),
        .reset      (reset),
        .req        (rif),
        .clr_err    (clr_err),
        .out_0      (out_0),
        .out_1      (out_1),
        .out_2      (out_2),
        .out_vld_0  (out_vld_0),
        .out_vld_1  (out_vld_1),
        .out_vld_2  (out_vld_2),
        .last_grant (last_grant),
        .err        (err)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input int unsigned idx, input int unsigned data);
        case (k)
            0: begin rif.req_valid_0 = v; rif.req_idx_0 = grant_id_t'(idx); rif.req_data_0 = data_t'(data); end
            1: begin rif.req_valid_1 = v; rif.req_idx_1 = grant_id_t'(idx); rif.req_data_1 = data_t'(data); end
            default: begin rif.req_valid_2 = v; rif.req_idx_2 = grant_id_t'(idx); rif.req_data_2 = data_t'(data); end
        endcase
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 3; k++) set_req(k, 1'b0, 0, 0);
    endtask

    // Inputs already driven at this negedge: check ready, then step past the edge.
    task automatic cycle(input string tag, input int unsigned exp_ready);
        #1;
        check(tag, {29'd0, rif.req_ready_2, rif.req_ready_1, rif.req_ready_0}, exp_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int unsigned o0, input int unsigned o1,
                               input int unsigned o2, input int unsigned vld,
                               input int unsigned lg, input int unsigned e);
        check({tag, ".out0"}, 32'(out_0), o0);
        check({tag, ".out1"}, 32'(out_1), o1);
        check({tag, ".out2"}, 32'(out_2), o2);
        check({tag, ".vld"}, {29'd0, out_vld_2, out_vld_1, out_vld_0}, vld);
        check({tag, ".last"}, 32'(last_grant), lg);
        check({tag, ".err"}, 32'(err), e);
    endtask

    initial begin
        reset   = 1'b1;
        clr_err = 1'b0;
        clear_reqs();
        set_req(0, 1'b1, 0, 3);
        @(negedge clk);
        cycle("rst_ready", 0);
        @(negedge clk);
        clear_reqs();
        reset = 1'b0;
        cycle("idle_ready", 0);
        check_state("idle", 0, 0, 0, 0, 0, 0);

        // All three valid: grants rotate 0,1,2,0,1,2 from ptr=0.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) set_req(k, 1'b1, k, k + 1);
            cycle($sformatf("rr%0d_ready", c), 1 << (c % 3));
            check($sformatf("rr%0d_last", c), 32'(last_grant), c % 3);
        end
        @(negedge clk);
        clear_reqs();
        check_state("rr_end", 1, 2, 3, 7, 2, 0);

        // Single write from requester 1.
        set_req(1, 1'b1, 2, 5);
        cycle("single_ready", 2);
        check_state("single", 1, 2, 5, 7, 1, 0);

        // ptr=2: requesters 0 and 2 valid, 2 goes first.
        @(negedge clk);
        clear_reqs();
        set_req(0, 1'b1, 0, 6);
        set_req(2, 1'b1, 1, 4);
        cycle("fair_a_ready", 4);
        check_state("fair_a", 1, 4, 5, 7, 2, 0);
        @(negedge clk);
        set_req(2, 1'b0, 0, 0);
        cycle("fair_b_ready", 1);
        check_state("fair_b", 6, 4, 5, 7, 0, 0);

        // Out-of-range write: handshake completes, data dropped, err set.
        @(negedge clk);
        clear_reqs();
        set_req(0, 1'b1, 3, 7);
        cycle("bad_ready", 1);
        check_state("bad", 6, 4, 5, 7, 0, 1);
        @(negedge clk);
        clr_err = 1'b1;
        cycle("bad_clr_ready", 1);
        check("bad_clr_err", 32'(err), 1);
        @(negedge clk);
        clear_reqs();
        cycle("clr_ready", 0);
        check("clr_err", 32'(err), 0);
        @(negedge clk);
        clr_err = 1'b0;
        set_req(1, 1'b1, 3, 1);
        cycle("bad2_ready", 2);
        check_state("bad2", 6, 4, 5, 7, 1, 1);

        // Reset mid-stream with pending requests; ptr returns to 0.
        @(negedge clk);
        clear_reqs();
        set_req(0, 1'b1, 0, 2);
        set_req(1, 1'b1, 1, 3);
        reset = 1'b1;
        cycle("mid_rst_ready", 0);
        check_state("mid_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        cycle("post_rst_ready", 1);
        check_state("post_rst", 2, 0, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
